// File: rtl/bindec_stream.sv
// rtl/bindec_stream.sv - streaming binary-to-one-hot decoder with 2-entry output buffer
module bindec_stream #(
  parameter int n = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [$clog2(n)-1:0] in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [n-1:0]         out,
  output logic                 out_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t       state;
  logic [n-1:0] tail_word;
  logic         tail_err;
  logic [n-1:0] dec_word;
  logic         dec_err;
  logic         accept;
  logic         pop;

  // Indices at or above n only exist when n is not a power of two.
  always_comb begin
    dec_word = '0;
    dec_err  = 1'b0;
    if (int'(in) < n) dec_word[in] = 1'b1;
    else              dec_err      = 1'b1;
  end

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // The head entry lives directly in the out/out_err/out_valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out       <= '0;
      out_err   <= 1'b0;
      tail_word <= '0;
      tail_err  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out       <= dec_word;
            out_err   <= dec_err;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out     <= dec_word;
            out_err <= dec_err;
          end else if (accept) begin
            tail_word <= dec_word;
            tail_err  <= dec_err;
            state     <= FULL;
            in_ready  <= 1'b0;
          end else if (pop) begin
            out       <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            out       <= tail_word;
            out_err   <= tail_err;
            tail_word <= '0;
            tail_err  <= 1'b0;
            state     <= ONE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          out       <= '0;
          out_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bindec_stream.sv
// tb/tb_bindec_stream.sv - self-checking bench for bindec_stream (n=8 and n=6 instances)
module tb_bindec_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  always #5 clk = ~clk;

  logic       v8 = 1'b0, r8 = 1'b0;
  logic [2:0] i8 = '0;
  logic       rdy8, ov8, oe8;
  logic [7:0] o8;

  logic       v6 = 1'b0, r6 = 1'b0;
  logic [2:0] i6 = '0;
  logic       rdy6, ov6, oe6;
  logic [5:0] o6;

  bindec_stream #(.n(8)) d8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in(i8),
    .out_valid(ov8), .out_ready(r8), .out(o8), .out_err(oe8)
  );

  bindec_stream #(.n(6)) d6 (
    .clk(clk), .reset(reset), .in_valid(v6), .in_ready(rdy6), .in(i6),
    .out_valid(ov6), .out_ready(r6), .out(o6), .out_err(oe6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO of {err, word} entries, capacity two.
  logic [8:0] q8[$];
  logic [8:0] q6[$];
  bit         mrdy8 = 1'b0;
  bit         mrdy6 = 1'b0;

  function automatic logic [8:0] expect_entry(int idx, int nn);
    if (idx < nn) return {1'b0, 8'(1 << idx)};
    return 9'h100;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q8.delete();
      q6.delete();
      mrdy8 = 1'b0;
      mrdy6 = 1'b0;
    end else begin
      bit acc8, pop8, acc6, pop6;
      acc8 = v8 && mrdy8;
      pop8 = (q8.size() > 0) && r8;
      acc6 = v6 && mrdy6;
      pop6 = (q6.size() > 0) && r6;
      if (pop8) void'(q8.pop_front());
      if (acc8) q8.push_back(expect_entry(int'(i8), 8));
      if (pop6) void'(q6.pop_front());
      if (acc6) q6.push_back(expect_entry(int'(i6), 6));
      mrdy8 = q8.size() < 2;
      mrdy6 = q6.size() < 2;
    end
  end

  always @(negedge clk) begin
    logic [8:0] h8, h6;
    h8 = (q8.size() > 0) ? q8[0] : 9'h0;
    h6 = (q6.size() > 0) ? q6[0] : 9'h0;
    chk("m8_valid", ov8, q8.size() > 0);
    chk("m8_word", o8, h8[7:0]);
    chk("m8_err", oe8, h8[8]);
    chk("m8_ready", rdy8, mrdy8);
    chk("m6_valid", ov6, q6.size() > 0);
    chk("m6_word", o6, h6[5:0]);
    chk("m6_err", oe6, h6[8]);
    chk("m6_ready", rdy6, mrdy6);
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_valid", ov8, 0);
    chk("rst_word", o8, 0);
    chk("rst_ready", rdy8, 0);
    chk("rst_ready6", rdy6, 0);
    #21 reset = 1'b0;
    edge1();
    chk("post_rst_ready", rdy8, 1);
    chk("post_rst_ready6", rdy6, 1);

    // Streaming 0..7 with consumer always ready.
    r8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v8 = 1'b1;
      i8 = 3'(k);
      edge1();
      chk("stream_word", o8, 8'h01 << k);
      chk("stream_valid", ov8, 1);
      chk("stream_err", oe8, 0);
    end
    v8 = 1'b0;
    edge1();
    chk("drain_valid", ov8, 0);
    chk("drain_word", o8, 0);
    chk("drain_err", oe8, 0);

    // Backpressure: 3 and 5 buffered, 6 held off.
    r8 = 1'b0;
    v8 = 1'b1;
    i8 = 3'd3;
    edge1();
    chk("bp_first", o8, 8'h08);
    i8 = 3'd5;
    edge1();
    chk("bp_full_ready", rdy8, 0);
    chk("bp_full_word", o8, 8'h08);
    i8 = 3'd6;
    edge1();
    chk("bp_hold_ready", rdy8, 0);
    chk("bp_hold_word", o8, 8'h08);
    r8 = 1'b1;
    edge1();
    chk("bp_pop1_word", o8, 8'h20);
    chk("bp_pop1_ready", rdy8, 1);
    edge1();
    chk("bp_pop2_word", o8, 8'h40);
    v8 = 1'b0;
    edge1();
    chk("bp_empty", ov8, 0);

    // Accept and pop together while ONE.
    r8 = 1'b0;
    v8 = 1'b1;
    i8 = 3'd2;
    edge1();
    chk("sim_head", o8, 8'h04);
    i8 = 3'd7;
    r8 = 1'b1;
    edge1();
    chk("sim_word", o8, 8'h80);
    chk("sim_ready", rdy8, 1);
    chk("sim_valid", ov8, 1);
    v8 = 1'b0;
    edge1();
    chk("sim_drain_valid", ov8, 0);
    chk("sim_drain_word", o8, 0);

    // Out-of-range indices on the n=6 instance.
    r6 = 1'b1;
    v6 = 1'b1;
    i6 = 3'd5;
    edge1();
    chk("oor5_word", o6, 6'b100000);
    chk("oor5_err", oe6, 0);
    i6 = 3'd6;
    edge1();
    chk("oor6_word", o6, 0);
    chk("oor6_err", oe6, 1);
    i6 = 3'd7;
    edge1();
    chk("oor7_word", o6, 0);
    chk("oor7_err", oe6, 1);
    v6 = 1'b0;
    edge1();
    chk("oor_drain_err", oe6, 0);

    // Reset with two entries buffered.
    r8 = 1'b0;
    v8 = 1'b1;
    i8 = 3'd1;
    edge1();
    i8 = 3'd4;
    edge1();
    v8 = 1'b0;
    chk("pre_rst_ready", rdy8, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", ov8, 0);
    chk("mid_rst_word", o8, 0);
    chk("mid_rst_err", oe8, 0);
    chk("mid_rst_ready", rdy8, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rel_ready", rdy8, 0);
    edge1();
    chk("rel_edge_ready", rdy8, 1);
    chk("rel_edge_valid", ov8, 0);
    edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
